// File: rtl/vramwriter_if.sv
// Bus bundle between the 68000 snoop pins, the VRAM writer and the external VRAM mux.
// CPU-side signals are raw asynchronous bus strobes/lines; VRAM-side signals are
// launched from pixClock flops inside the writer.
interface vramwriter_if;
   logic [22:0] cpuAddr;
   logic [15:0] cpuData;
   logic        nAS;
   logic        nUDS;
   logic        nLDS;
   logic        cpuRnW;
   logic [14:0] vramAddr;
   logic [7:0]  vramDout;
   logic        nvramWE;
   logic        wrActive;

   // Writer view: snoops the CPU bus, drives the VRAM write port.
   modport master (
      input  cpuAddr, cpuData, nAS, nUDS, nLDS, cpuRnW,
      output vramAddr, vramDout, nvramWE, wrActive
   );

   // Environment view: drives the CPU bus, observes the VRAM write port.
   modport slave (
      output cpuAddr, cpuData, nAS, nUDS, nLDS, cpuRnW,
      input  vramAddr, vramDout, nvramWE, wrActive
   );
endinterface

// File: rtl/vramwriter.sv
// vramwriter: captures 68000 writes that land in the main screen buffer and
// replays them as byte writes into VRAM in the cycles vgaout does not own.
//
// Internal handshake: the capture logic pushes an entry (valid = accepted
// capture in the window) and the FIFO accepts it (ready) when it is not full or
// when the drain FSM pops in the same cycle; the drain FSM consumes the head
// entry (valid = FIFO not empty) and acknowledges it with pop on the final
// STROBE of that entry. A valid capture without ready is dropped and flagged.
module vramwriter #(
   parameter logic [23:0] FB_BASE    = 24'h3FA700,
   parameter logic [15:0] FB_SIZE    = 16'h5580,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic         pixClock,
   input  logic         nReset,
   vramwriter_if.master bus,
   input  logic         vidSlot,
   input  logic         vidSlotNext,
   output logic         fifoEmpty,
   output logic         overflow,
   output logic [1:0]   dbg_state
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [PTR_W:0]   CNT_ONE = 1;
   // Window bounds widened by one bit so FB_BASE+FB_SIZE cannot wrap.
   localparam logic [24:0]      WIN_LO  = {1'b0, FB_BASE};
   localparam logic [24:0]      WIN_HI  = {1'b0, FB_BASE} + {9'b0, FB_SIZE};
   // Word index of FB_BASE within a 32 KB VRAM; FB_BASE is even, so the
   // 15-bit byte offset is always {word_offset, byte_select}.
   localparam logic [13:0]      BASE_WORD = FB_BASE[14:1];

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_NEXT   = 2'd3
   } state_t;

   typedef struct packed {
      logic [13:0] word;
      logic [15:0] data;
      logic        ue;
      logic        le;
   } entry_t;

   // Synchronizer bit order: {cpuRnW, nLDS, nUDS, nAS}.
   logic [3:0] sync1_q, sync1_d;
   logic [3:0] sync2_q, sync2_d;
   logic       armed_q, armed_d;

   entry_t           mem_q [FIFO_DEPTH];
   entry_t           mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             empty_q, empty_d;
   logic             overflow_q, overflow_d;

   state_t      state_q, state_d;
   logic [14:0] addr_q, addr_d;
   logic [7:0]  dout_q, dout_d;
   logic        upper_q, upper_d;

   logic        as_s, uds_s, lds_s, rnw_s;
   logic [24:0] byte_addr;
   logic        in_window;
   logic        capture;
   entry_t      new_entry;
   logic        push_req;
   logic        push;
   logic        pop;
   entry_t      head;
   logic        slot_free;

   assign as_s  = sync2_q[0];
   assign uds_s = sync2_q[1];
   assign lds_s = sync2_q[2];
   assign rnw_s = sync2_q[3];

   // Strobe synchronizers, once-per-bus-cycle capture qualifier and window check.
   always_comb begin
      sync1_d   = {bus.cpuRnW, bus.nLDS, bus.nUDS, bus.nAS};
      sync2_d   = sync1_q;
      byte_addr = {1'b0, bus.cpuAddr, 1'b0};
      in_window = (byte_addr >= WIN_LO) && (byte_addr < WIN_HI);
      capture   = !as_s && !rnw_s && (!uds_s || !lds_s) && armed_q;
      armed_d   = armed_q;
      if (capture) begin
         armed_d = 1'b0;
      end else if (as_s) begin
         armed_d = 1'b1;
      end
      new_entry.word = bus.cpuAddr[13:0] - BASE_WORD;
      new_entry.data = bus.cpuData;
      new_entry.ue   = !uds_s;
      new_entry.le   = !lds_s;
   end

   // Capture FIFO: a pop in the same cycle frees the slot a full push needs.
   always_comb begin
      push_req   = capture && in_window;
      push       = push_req && ((count_q != DEPTH_C) || pop);
      overflow_d = overflow_q || (push_req && !push);
      mem_d      = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = new_entry;
      end
      wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      empty_d = (count_d == '0);
   end

   // Drain FSM: next state, write address/data and FIFO pop.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      dout_d    = dout_q;
      upper_d   = upper_q;
      pop       = 1'b0;
      head      = mem_q[rd_ptr_q];
      slot_free = !vidSlot && !vidSlotNext;
      case (state_q)
         ST_IDLE: begin
            if ((count_q != '0) && slot_free) begin
               state_d = ST_SETUP;
               upper_d = head.ue;
               addr_d  = {head.word, !head.ue};
               dout_d  = head.ue ? head.data[15:8] : head.data[7:0];
            end
         end
         ST_SETUP: begin
            // The IDLE/NEXT check only covers this cycle; if a video slot
            // would land on the STROBE cycle, back off and retry the same byte.
            if (vidSlotNext) begin
               state_d = (!upper_q && head.ue) ? ST_NEXT : ST_IDLE;
            end else begin
               state_d = ST_STROBE;
            end
         end
         ST_STROBE: begin
            if (upper_q && head.le) begin
               state_d = ST_NEXT;
            end else begin
               pop     = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_NEXT: begin
            if (slot_free) begin
               state_d = ST_SETUP;
               upper_d = 1'b0;
               addr_d  = {head.word, 1'b1};
               dout_d  = head.data[7:0];
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // All state registers; synchronous active-low reset.
   always_ff @(posedge pixClock) begin
      if (!nReset) begin
         sync1_q    <= 4'hF;
         sync2_q    <= 4'hF;
         armed_q    <= 1'b1;
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         dout_q     <= '0;
         upper_q    <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         armed_q    <= armed_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         addr_q     <= addr_d;
         dout_q     <= dout_d;
         upper_q    <= upper_d;
      end
   end

   assign bus.vramAddr = addr_q;
   assign bus.vramDout = dout_q;
   assign bus.wrActive = (state_q == ST_SETUP) || (state_q == ST_STROBE);
   assign bus.nvramWE  = (state_q != ST_STROBE);
   assign fifoEmpty    = empty_q;
   assign overflow     = overflow_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_vramwriter.sv
// Directed bench for vramwriter: vector table for single bus cycles, plus
// hand sequences for slot deferral, FIFO overflow and reset during STROBE.
module tb_vramwriter;

   localparam logic [23:0] FB_BASE = 24'h3FA700;

   logic       pixClock = 1'b0;
   logic       nReset   = 1'b0;
   logic       vidSlot  = 1'b0;
   logic       vidSlotNext = 1'b0;
   logic       fifoEmpty;
   logic       overflow;
   logic [1:0] dbg_state;

   vramwriter_if bus();

   vramwriter #(
      .FB_BASE(FB_BASE),
      .FB_SIZE(16'h5580),
      .FIFO_DEPTH(4)
   ) dut (
      .pixClock(pixClock),
      .nReset(nReset),
      .bus(bus),
      .vidSlot(vidSlot),
      .vidSlotNext(vidSlotNext),
      .fifoEmpty(fifoEmpty),
      .overflow(overflow),
      .dbg_state(dbg_state)
   );

   // Clock: 10 ns period.
   always #5 pixClock = ~pixClock;

   typedef struct {
      logic [23:0] b;
      logic [15:0] data;
      logic        nuds;
      logic        nlds;
      logic        rnw;
      int          n_exp;
      logic [22:0] w0;
      logic [22:0] w1;
      string       name;
   } vec_t;

   vec_t        vecs[7];
   logic [22:0] exp_q[$];
   logic [22:0] got_q[$];
   int          checks = 0;
   int          failures = 0;
   int          we_long = 0;
   int          slot_viol = 0;
   logic        seen_busy = 1'b0;
   logic        prev_we_low = 1'b0;
   int          slot_mode = 0;
   logic [2:0]  hcnt = 3'd0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Video slot generator: 0 = no slots, 1 = one slot every 8 cycles, 2 = held.
   initial begin
      forever begin
         @(posedge pixClock);
         #1;
         hcnt = hcnt + 3'd1;
         case (slot_mode)
            1: begin
               vidSlot     = (hcnt == 3'd7);
               vidSlotNext = (hcnt == 3'd6);
            end
            2: begin
               vidSlot     = 1'b1;
               vidSlotNext = 1'b1;
            end
            default: begin
               vidSlot     = 1'b0;
               vidSlotNext = 1'b0;
            end
         endcase
      end
   end

   // Write-port monitor: logs every strobe, flags long strobes and slot clashes.
   initial begin
      forever begin
         @(negedge pixClock);
         if (!bus.nvramWE) begin
            got_q.push_back({bus.vramAddr, bus.vramDout});
            if (prev_we_low) we_long++;
         end
         prev_we_low = !bus.nvramWE;
         if (bus.wrActive && vidSlot) slot_viol++;
         if (!fifoEmpty) seen_busy = 1'b1;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog elapsed checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic cpu_cycle(input logic [23:0] b, input logic [15:0] d,
                            input logic nuds, input logic nlds, input logic rnw);
      @(posedge pixClock);
      #2;
      bus.cpuAddr = b[23:1];
      bus.cpuData = d;
      bus.cpuRnW  = rnw;
      bus.nAS     = 1'b0;
      bus.nUDS    = nuds;
      bus.nLDS    = nlds;
      repeat (8) @(posedge pixClock);
      #2;
      bus.nAS    = 1'b1;
      bus.nUDS   = 1'b1;
      bus.nLDS   = 1'b1;
      bus.cpuRnW = 1'b1;
      repeat (4) @(posedge pixClock);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (!(fifoEmpty === 1'b1 && dbg_state === 2'd0) && n < 200) begin
         @(negedge pixClock);
         n++;
      end
      check({tag, "_drain_in_time"}, {31'b0, (n < 200)}, 32'd1);
      repeat (2) @(negedge pixClock);
   endtask

   task automatic compare_writes(input string tag);
      int n;
      check({tag, "_write_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_write%0d_addr_data", tag, i), {9'b0, got_q[i]}, {9'b0, exp_q[i]});
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_nvramWE"},   {31'b0, bus.nvramWE},  32'd1);
      check({tag, "_wrActive"},  {31'b0, bus.wrActive}, 32'd0);
      check({tag, "_vramAddr"},  {17'b0, bus.vramAddr}, 32'd0);
      check({tag, "_vramDout"},  {24'b0, bus.vramDout}, 32'd0);
      check({tag, "_fifoEmpty"}, {31'b0, fifoEmpty},    32'd1);
      check({tag, "_overflow"},  {31'b0, overflow},     32'd0);
      check({tag, "_state"},     {30'b0, dbg_state},    32'd0);
   endtask

   initial begin
      vecs[0] = '{b: FB_BASE,           data: 16'hA55A, nuds: 1'b0, nlds: 1'b0, rnw: 1'b0, n_exp: 2,
                  w0: {15'h0000, 8'hA5}, w1: {15'h0001, 8'h5A}, name: "word_at_base"};
      vecs[1] = '{b: FB_BASE + 24'h40,  data: 16'h00C3, nuds: 1'b1, nlds: 1'b0, rnw: 1'b0, n_exp: 1,
                  w0: {15'h0041, 8'hC3}, w1: 23'h0,             name: "lower_byte_only"};
      vecs[2] = '{b: FB_BASE + 24'h100, data: 16'hBEEF, nuds: 1'b0, nlds: 1'b1, rnw: 1'b0, n_exp: 1,
                  w0: {15'h0100, 8'hBE}, w1: 23'h0,             name: "upper_byte_only"};
      vecs[3] = '{b: FB_BASE - 24'd2,   data: 16'h1234, nuds: 1'b0, nlds: 1'b0, rnw: 1'b0, n_exp: 0,
                  w0: 23'h0,             w1: 23'h0,             name: "below_window"};
      vecs[4] = '{b: FB_BASE + 24'h5580, data: 16'h5678, nuds: 1'b0, nlds: 1'b0, rnw: 1'b0, n_exp: 0,
                  w0: 23'h0,             w1: 23'h0,             name: "at_window_end"};
      vecs[5] = '{b: FB_BASE,           data: 16'h9999, nuds: 1'b0, nlds: 1'b0, rnw: 1'b1, n_exp: 0,
                  w0: 23'h0,             w1: 23'h0,             name: "read_cycle"};
      vecs[6] = '{b: FB_BASE + 24'h557E, data: 16'hCAFE, nuds: 1'b0, nlds: 1'b0, rnw: 1'b0, n_exp: 2,
                  w0: {15'h557E, 8'hCA}, w1: {15'h557F, 8'hFE}, name: "last_word"};

      // Clock/reset.
      bus.cpuAddr = '0;
      bus.cpuData = '0;
      bus.nAS     = 1'b1;
      bus.nUDS    = 1'b1;
      bus.nLDS    = 1'b1;
      bus.cpuRnW  = 1'b1;
      nReset      = 1'b0;
      repeat (3) @(posedge pixClock);
      @(negedge pixClock);
      check_reset_values("reset");
      @(posedge pixClock);
      #2;
      nReset = 1'b1;
      repeat (3) @(posedge pixClock);
      got_q.delete();

      // Single bus cycles from the vector table.
      for (int i = 0; i < 7; i++) begin
         seen_busy = 1'b0;
         cpu_cycle(vecs[i].b, vecs[i].data, vecs[i].nuds, vecs[i].nlds, vecs[i].rnw);
         wait_drain(vecs[i].name);
         if (vecs[i].n_exp > 0) exp_q.push_back(vecs[i].w0);
         if (vecs[i].n_exp > 1) exp_q.push_back(vecs[i].w1);
         compare_writes(vecs[i].name);
         check({vecs[i].name, "_fifo_used"}, {31'b0, seen_busy}, {31'b0, (vecs[i].n_exp != 0)});
         check({vecs[i].name, "_overflow"}, {31'b0, overflow}, 32'd0);
      end

      // Word writes at every phase of a periodic video slot.
      slot_mode = 1;
      for (int p = 0; p < 8; p++) begin
         repeat (p) @(posedge pixClock);
         cpu_cycle(FB_BASE + 24'(32'h200 + p * 4), {8'h10 + 8'(p), 8'h80 + 8'(p)}, 1'b0, 1'b0, 1'b0);
         wait_drain($sformatf("slot_phase%0d", p));
         exp_q.push_back({15'(32'h200 + p * 4), 8'h10 + 8'(p)});
         exp_q.push_back({15'(32'h201 + p * 4), 8'h80 + 8'(p)});
         compare_writes($sformatf("slot_phase%0d", p));
      end
      slot_mode = 0;
      check("slot_rule_periodic", 32'(slot_viol), 32'd0);

      // Five word writes while video holds VRAM: four queue, the fifth overflows.
      slot_mode = 2;
      repeat (3) @(posedge pixClock);
      for (int i = 0; i < 5; i++) begin
         cpu_cycle(FB_BASE + 24'(32'h300 + i * 2), {8'hC0 + 8'(i), 8'h30 + 8'(i)}, 1'b0, 1'b0, 1'b0);
      end
      repeat (4) @(negedge pixClock);
      check("ovf_fifo_not_empty", {31'b0, fifoEmpty}, 32'd0);
      check("ovf_flag_set", {31'b0, overflow}, 32'd1);
      check("ovf_no_write_during_slot", 32'(got_q.size()), 32'd0);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({15'(32'h300 + i * 2), 8'hC0 + 8'(i)});
         exp_q.push_back({15'(32'h301 + i * 2), 8'h30 + 8'(i)});
      end
      slot_mode = 0;
      wait_drain("ovf_release");
      compare_writes("ovf_release");
      check("ovf_flag_sticky", {31'b0, overflow}, 32'd1);
      check("slot_rule_hold", 32'(slot_viol), 32'd0);

      // Reset sampled at the end of the upper-byte STROBE of a word write.
      exp_q.push_back({15'h0010, 8'h7E});
      fork
         cpu_cycle(FB_BASE + 24'h10, 16'h7E81, 1'b0, 1'b0, 1'b0);
         begin
            int n = 0;
            while (dbg_state !== 2'd2 && n < 100) begin
               @(negedge pixClock);
               n++;
            end
            check("rst_strobe_reached", {31'b0, (n < 100)}, 32'd1);
            nReset = 1'b0;
            @(negedge pixClock);
            check_reset_values("rst_mid");
         end
      join
      @(posedge pixClock);
      #2;
      nReset = 1'b1;
      repeat (30) @(posedge pixClock);
      @(negedge pixClock);
      compare_writes("rst_mid_no_lower");
      check("rst_mid_fifo_empty", {31'b0, fifoEmpty}, 32'd1);

      check("strobe_one_cycle", 32'(we_long), 32'd0);
      check("slot_rule_final", 32'(slot_viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
